// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions and FSM states.
// No logic; constants only.
// Not applicable (no handshakes).
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   // Status / Cause field positions
   localparam int ST_IE_BIT   = 0;
   localparam int ST_EXL_BIT  = 1;
   localparam int ST_IM_LSB   = 8;
   localparam int CA_EXC_LSB  = 2;
   localparam int CA_IP_LSB   = 8;
   localparam int IP_TIMER    = 7;   // index within the 8-bit IP field (Cause bit 15)
   localparam int IP_HW_LSB   = 2;   // irq[0] lands at IP[2] (Cause bit 10)

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_REDIR = 1'b1
   } exc_state_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the timer-pending bit (Cause.IP[15]).
// Count increments every cycle; writes take effect at the next edge.
// No backpressure; always accepts writes.
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pend
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        pend_q, pend_d;

   // Next state: a Count write overrides the increment; a Compare write clears the pending bit.
   always_comb begin
      count_d   = count_we ? wdata : count_q + 32'd1;
      compare_d = compare_we ? wdata : compare_q;
      pend_d    = pend_q;
      if (compare_we)
         pend_d = 1'b0;
      else if (!count_we && (count_d == compare_q))
         pend_d = 1'b1;
   end

   // Timer state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   assign count      = count_q;
   assign compare    = compare_q;
   assign timer_pend = pend_q;

endmodule

// File: rtl/exc_ctrl.sv
// CP0 register file plus exception/interrupt take, flush and PC-redirect sequencing.
// flush is combinational in the take cycle; redirect follows one cycle later (2-cycle penalty).
// No backpressure; take conditions are ignored while a redirect is in flight.
module exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter int          NUM_IRQ    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_valid,
   input  logic [31:0]        mem_pc,
   input  logic               mem_syscall,
   input  logic               mem_unknown,
   input  logic               mem_ovf,
   input  logic               mem_eret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               cp0_we,
   input  logic [4:0]         cp0_waddr,
   input  logic [31:0]        cp0_wdata,
   input  logic [4:0]         cp0_raddr,
   output logic [31:0]        cp0_rdata,
   output logic               flush,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic [31:0]        epc
);

   exc_state_t         state_q, state_d;
   logic               ie_q, ie_d;
   logic               exl_q, exl_d;
   logic [7:0]         im_q, im_d;
   logic [4:0]         exc_code_q, exc_code_d;
   logic [1:0]         ip_sw_q, ip_sw_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic [31:0]        epc_q, epc_d;
   logic [31:0]        target_q, target_d;

   logic [31:0] count, compare;
   logic        timer_pend;
   logic [4:0]  ip_hw;
   logic [7:0]  ip;
   logic        exc_hit, irq_hit, take, eret_go, wr_ok;
   logic [4:0]  code;
   logic [31:0] status_rd, cause_rd;

   // Assemble the IP field and the readable Status/Cause images
   always_comb begin
      ip_hw                = '0;
      ip_hw[NUM_IRQ-1:0]   = irq_q;
      ip                   = {timer_pend, ip_hw, ip_sw_q};
      status_rd            = '0;
      status_rd[ST_IE_BIT] = ie_q;
      status_rd[ST_EXL_BIT] = exl_q;
      status_rd[ST_IM_LSB +: 8] = im_q;
      cause_rd             = '0;
      cause_rd[CA_EXC_LSB +: 5] = exc_code_q;
      cause_rd[CA_IP_LSB +: 8]  = ip;
   end

   // Take decision and prioritised exception code
   always_comb begin
      exc_hit = mem_unknown | mem_syscall | mem_ovf;
      irq_hit = ie_q & ~exl_q & (|(ip & im_q));
      take    = 1'b0;
      eret_go = 1'b0;
      if (state_q == S_IDLE && mem_valid) begin
         take    = exc_hit | (~mem_eret & irq_hit);
         eret_go = ~exc_hit & mem_eret;
      end
      if (mem_unknown)      code = EXC_RI;
      else if (mem_syscall) code = EXC_SYS;
      else if (mem_ovf)     code = EXC_OV;
      else                  code = EXC_INT;
      // The instruction issuing the write is squashed by a take
      wr_ok = cp0_we & ~take;
   end

   // Next-state: mtc0 updates, then take/eret updates with priority, plus FSM
   always_comb begin
      state_d    = state_q;
      ie_d       = ie_q;
      exl_d      = exl_q;
      im_d       = im_q;
      exc_code_d = exc_code_q;
      ip_sw_d    = ip_sw_q;
      epc_d      = epc_q;
      target_d   = target_q;
      if (wr_ok) begin
         case (cp0_waddr)
            CP0_STATUS: begin
               ie_d  = cp0_wdata[ST_IE_BIT];
               exl_d = cp0_wdata[ST_EXL_BIT];
               im_d  = cp0_wdata[ST_IM_LSB +: 8];
            end
            CP0_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LSB +: 2];
            CP0_EPC:   epc_d   = cp0_wdata;
            default: ;
         endcase
      end
      case (state_q)
         S_IDLE: begin
            if (take) begin
               epc_d      = mem_pc;
               exc_code_d = code;
               exl_d      = 1'b1;
               target_d   = EXC_VECTOR;
               state_d    = S_REDIR;
            end else if (eret_go) begin
               exl_d    = 1'b0;
               target_d = epc_q;
               state_d  = S_REDIR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      flush    = take | eret_go | (state_q == S_REDIR);
      redirect = (state_q == S_REDIR);
   end

   // CP0, interrupt sampling and FSM state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= '0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
         irq_q      <= '0;
         epc_q      <= '0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         exc_code_q <= exc_code_d;
         ip_sw_q    <= ip_sw_d;
         irq_q      <= irq;
         epc_q      <= epc_d;
         target_q   <= target_d;
      end
   end

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_ok && cp0_waddr == CP0_COUNT),
      .compare_we (wr_ok && cp0_waddr == CP0_COMPARE),
      .wdata      (cp0_wdata),
      .count      (count),
      .compare    (compare),
      .timer_pend (timer_pend)
   );

   // mfc0 read mux; reads pre-edge register values, no write bypass
   always_comb begin
      case (cp0_raddr)
         CP0_COUNT:   cp0_rdata = count;
         CP0_COMPARE: cp0_rdata = compare;
         CP0_STATUS:  cp0_rdata = status_rd;
         CP0_CAUSE:   cp0_rdata = cause_rd;
         CP0_EPC:     cp0_rdata = epc_q;
         default:     cp0_rdata = '0;
      endcase
   end

   assign redirect_pc = target_q;
   assign epc         = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled later in the same cycle.
// No backpressure in the DUT; every step is a fixed number of cycles.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_syscall, mem_unknown, mem_ovf, mem_eret;
   logic [4:0]  irq;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        flush, redirect;
   logic [31:0] redirect_pc, epc;

   int checks = 0;
   int errors = 0;
   logic [31:0] v;

   exc_ctrl #(.EXC_VECTOR(32'h0000_0040), .NUM_IRQ(5)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_syscall(mem_syscall), .mem_unknown(mem_unknown), .mem_ovf(mem_ovf),
      .mem_eret(mem_eret), .irq(irq), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
      .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
      .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cp0_raddr = a;
      #1;
      d = cp0_rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
      tick();
      cp0_we = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_valid = 0; mem_pc = 0; mem_syscall = 0; mem_unknown = 0;
      mem_ovf = 0; mem_eret = 0; irq = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
      cp0_raddr = 0;
      tick(); tick();
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_epc", epc, 32'd0);
      rd(5'd12, v); chk("rst_status", v, 32'd0);
      rd(5'd9, v);  chk("rst_count", v, 32'd0);
      rst = 1'b0;
      tick();

      // syscall with IE=0
      mem_valid = 1; mem_syscall = 1; mem_pc = 32'h100;
      #1;
      chk("sys_T_flush", {31'b0, flush}, 32'd1);
      chk("sys_T_redirect", {31'b0, redirect}, 32'd0);
      tick();
      mem_valid = 0; mem_syscall = 0;
      #1;
      chk("sys_T1_flush", {31'b0, flush}, 32'd1);
      chk("sys_T1_redirect", {31'b0, redirect}, 32'd1);
      chk("sys_T1_pc", redirect_pc, 32'h40);
      chk("sys_epc", epc, 32'h100);
      rd(5'd13, v); chk("sys_cause", v, 32'h20);
      rd(5'd12, v); chk("sys_status", v, 32'h2);
      tick();
      chk("sys_T2_redirect", {31'b0, redirect}, 32'd0);
      chk("sys_T2_flush", {31'b0, flush}, 32'd0);

      // external interrupt: IE=1, IM[10]
      wr(5'd12, 32'h0401);
      irq = 5'b00001; mem_valid = 1; mem_pc = 32'h200;
      #1;
      chk("irq_c0_flush", {31'b0, flush}, 32'd0);
      tick();
      chk("irq_T_flush", {31'b0, flush}, 32'd1);
      tick();
      mem_valid = 0;
      chk("irq_T1_redirect", {31'b0, redirect}, 32'd1);
      chk("irq_T1_pc", redirect_pc, 32'h40);
      chk("irq_epc", epc, 32'h200);
      rd(5'd13, v); chk("irq_cause", v, 32'h400);
      rd(5'd12, v); chk("irq_status", v, 32'h403);
      tick();

      // interrupt masked while EXL=1
      mem_valid = 1; mem_pc = 32'h300;
      #1;
      chk("irq_exl_flush", {31'b0, flush}, 32'd0);
      tick();
      chk("irq_exl_redirect", {31'b0, redirect}, 32'd0);
      mem_valid = 0;

      // priority: unknown over ovf over pending interrupt
      wr(5'd12, 32'h0401);
      mem_valid = 1; mem_unknown = 1; mem_ovf = 1; mem_pc = 32'h500;
      #1;
      chk("pri_T_flush", {31'b0, flush}, 32'd1);
      tick();
      mem_valid = 0; mem_unknown = 0; mem_ovf = 0;
      chk("pri_T1_redirect", {31'b0, redirect}, 32'd1);
      chk("pri_epc", epc, 32'h500);
      rd(5'd13, v); chk("pri_cause", v, 32'h428);
      tick();
      chk("pri_T2_redirect", {31'b0, redirect}, 32'd0);
      chk("pri_T2_flush", {31'b0, flush}, 32'd0);

      // eret to EPC=0x204, syscall during REDIRECT ignored
      irq = 0;
      wr(5'd14, 32'h204);
      mem_valid = 1; mem_eret = 1;
      #1;
      chk("eret_T_flush", {31'b0, flush}, 32'd1);
      tick();
      mem_eret = 0; mem_syscall = 1; mem_pc = 32'h900;
      #1;
      chk("eret_T1_redirect", {31'b0, redirect}, 32'd1);
      chk("eret_T1_pc", redirect_pc, 32'h204);
      rd(5'd12, v); chk("eret_status", v, 32'h401);
      mem_valid = 0; mem_syscall = 0;
      tick();
      chk("eret_T2_redirect", {31'b0, redirect}, 32'd0);
      chk("eret_epc_kept", epc, 32'h204);
      rd(5'd13, v); chk("eret_cause_kept", v, 32'h28);

      // timer: Compare=5, Count=0
      wr(5'd12, 32'h0);
      wr(5'd11, 32'd5);
      wr(5'd9, 32'd0);
      rd(5'd9, v); chk("tmr_count0", v, 32'd0);
      tick(); tick(); tick(); tick();
      rd(5'd9, v); chk("tmr_count4", v, 32'd4);
      rd(5'd13, v); chk("tmr_cause4", v, 32'h28);
      tick();
      rd(5'd9, v); chk("tmr_count5", v, 32'd5);
      rd(5'd13, v); chk("tmr_cause5", v, 32'h8028);
      wr(5'd11, 32'd7);
      rd(5'd9, v); chk("tmr_count6", v, 32'd6);
      rd(5'd13, v); chk("tmr_clear", v, 32'h28);
      wr(5'd9, 32'hFFFF_FFFE);
      rd(5'd9, v); chk("wrap_fffe", v, 32'hFFFF_FFFE);
      tick();
      rd(5'd9, v); chk("wrap_ffff", v, 32'hFFFF_FFFF);
      tick();
      rd(5'd9, v); chk("wrap_zero", v, 32'd0);

      // software IP bits and an unmapped register
      wr(5'd13, 32'h0000_0300);
      rd(5'd13, v); chk("sw_ip", v, 32'h328);
      wr(5'd3, 32'hFFFF_FFFF);
      rd(5'd3, v); chk("unmapped_rd", v, 32'd0);

      // mtc0 EPC coinciding with an ovf take is discarded
      cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
      mem_valid = 1; mem_ovf = 1; mem_pc = 32'h600;
      #1;
      chk("ovf_T_flush", {31'b0, flush}, 32'd1);
      tick();
      cp0_we = 0; mem_valid = 0; mem_ovf = 0;
      chk("ovf_epc", epc, 32'h600);
      rd(5'd13, v); chk("ovf_cause", v, 32'h330);
      chk("ovf_T1_redirect", {31'b0, redirect}, 32'd1);

      // reset during REDIRECT aborts immediately
      rst = 1'b1;
      #1;
      chk("rstr_redirect", {31'b0, redirect}, 32'd0);
      chk("rstr_flush", {31'b0, flush}, 32'd0);
      chk("rstr_redirect_pc", redirect_pc, 32'd0);
      chk("rstr_epc", epc, 32'd0);
      rd(5'd13, v); chk("rstr_cause", v, 32'd0);
      rd(5'd12, v); chk("rstr_status", v, 32'd0);
      rd(5'd11, v); chk("rstr_compare", v, 32'd0);
      rd(5'd9, v);  chk("rstr_count", v, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_redirect", {31'b0, redirect}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
